// File: rtl/btn_bounce_gen.sv
// Mechanical push-button emulator: one press/release with LFSR-timed contact bounce on each edge.
// All outputs are registered; start is sampled only in IDLE and abort forces IDLE without a done pulse.
module btn_bounce_gen #(
   parameter int unsigned BOUNCE_N    = 6,
   parameter int unsigned BOUNCE_MIN  = 100,
   parameter logic [15:0] BOUNCE_MASK = 16'h03FF,
   parameter int unsigned HOLD_CYC    = 200000,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic abort,
   output logic btn_out,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {IDLE, P_BOUNCE, HOLD, R_BOUNCE} state_t;

   localparam bit          CLEAN    = (BOUNCE_N == 0);
   localparam logic [16:0] TOG_LAST = 17'(2 * BOUNCE_N);
   localparam logic [16:0] MIN_LEN  = 17'(BOUNCE_MIN);
   localparam logic [23:0] HOLD_LD  = 24'(HOLD_CYC);

   state_t      state, state_nxt;
   logic [15:0] lfsr, lfsr_nxt, lfsr_adv;
   logic [16:0] ivl_cnt, ivl_cnt_nxt, ivl_len;
   logic [16:0] tog_cnt, tog_cnt_nxt;
   logic [23:0] hold_cnt, hold_cnt_nxt;
   logic        btn_nxt, busy_nxt, done_nxt;

   // The LFSR only steps when an interval is loaded, so the bounce pattern repeats after every reset.
   assign lfsr_adv = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
   assign ivl_len  = MIN_LEN + {1'b0, lfsr & BOUNCE_MASK};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         lfsr     <= SEED;
         ivl_cnt  <= '0;
         tog_cnt  <= '0;
         hold_cnt <= '0;
         btn_out  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         lfsr     <= lfsr_nxt;
         ivl_cnt  <= ivl_cnt_nxt;
         tog_cnt  <= tog_cnt_nxt;
         hold_cnt <= hold_cnt_nxt;
         btn_out  <= btn_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      lfsr_nxt     = lfsr;
      ivl_cnt_nxt  = ivl_cnt;
      tog_cnt_nxt  = tog_cnt;
      hold_cnt_nxt = hold_cnt;
      btn_nxt      = btn_out;
      busy_nxt     = busy;
      done_nxt     = 1'b0;

      if (abort && state != IDLE) begin
         state_nxt    = IDLE;
         ivl_cnt_nxt  = '0;
         tog_cnt_nxt  = '0;
         hold_cnt_nxt = '0;
         btn_nxt      = 1'b0;
         busy_nxt     = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A coincident abort still wins over start here, though it changes nothing else.
               if (start && !abort) begin
                  btn_nxt     = 1'b1;
                  busy_nxt    = 1'b1;
                  tog_cnt_nxt = '0;
                  if (CLEAN) begin
                     state_nxt    = HOLD;
                     hold_cnt_nxt = HOLD_LD;
                  end else begin
                     state_nxt   = P_BOUNCE;
                     ivl_cnt_nxt = ivl_len;
                     lfsr_nxt    = lfsr_adv;
                  end
               end
            end
            P_BOUNCE, R_BOUNCE: begin
               if (ivl_cnt == 17'd1) begin
                  btn_nxt = ~btn_out;
                  if (tog_cnt + 17'd1 == TOG_LAST) begin
                     tog_cnt_nxt = '0;
                     ivl_cnt_nxt = '0;
                     if (state == P_BOUNCE) begin
                        state_nxt    = HOLD;
                        hold_cnt_nxt = HOLD_LD;
                     end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                     end
                  end else begin
                     tog_cnt_nxt = tog_cnt + 17'd1;
                     ivl_cnt_nxt = ivl_len;
                     lfsr_nxt    = lfsr_adv;
                  end
               end else begin
                  ivl_cnt_nxt = ivl_cnt - 17'd1;
               end
            end
            HOLD: begin
               if (hold_cnt == 24'd1) begin
                  btn_nxt      = 1'b0;
                  hold_cnt_nxt = '0;
                  if (CLEAN) begin
                     state_nxt = IDLE;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt   = R_BOUNCE;
                     ivl_cnt_nxt = ivl_len;
                     lfsr_nxt    = lfsr_adv;
                  end
               end else begin
                  hold_cnt_nxt = hold_cnt - 24'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Directed bench: fixed-interval instance checked edge by edge against change-point tables,
// plus an LFSR-interval instance checked against hand-computed intervals and for repeatability.
module tb_btn_bounce_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic btn_out, busy, done;
   logic btn_r, busy_r, done_r;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   btn_bounce_gen #(.BOUNCE_N(2), .BOUNCE_MIN(3), .BOUNCE_MASK(16'h0000), .HOLD_CYC(10))
      dut (.clk(clk), .rst(rst), .start(start), .abort(abort),
           .btn_out(btn_out), .busy(busy), .done(done));

   btn_bounce_gen #(.BOUNCE_N(2), .BOUNCE_MIN(3), .BOUNCE_MASK(16'h000F), .HOLD_CYC(10))
      dut_r (.clk(clk), .rst(rst), .start(start), .abort(abort),
             .btn_out(btn_r), .busy(busy_r), .done(done_r));

   typedef struct {
      int   e;
      logic b;
      logic y;
      logic d;
   } chk_t;

   chk_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int e, input logic b, input logic y, input logic d);
      chk_t c;
      c.e = e; c.b = b; c.y = y; c.d = d;
      tbl.push_back(c);
   endtask

   // Change points of one undisturbed sequence started at edge 0.
   task automatic fill_normal(input int off, input int upto);
      int   ne[11] = '{0, 3, 6, 9, 12, 22, 25, 28, 31, 34, 35};
      logic nb[11] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
      logic ny[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      logic nd[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 11; i++)
         if (ne[i] + off <= upto) add(ne[i] + off, nb[i], ny[i], nd[i]);
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      tick();
      rst = 1'b0;
      chk({nm, " rst btn"}, {31'd0, btn_out}, 0);
      chk({nm, " rst busy"}, {31'd0, busy}, 0);
      chk({nm, " rst done"}, {31'd0, done}, 0);
   endtask

   // start pulses at edge 0 and st2, abort at ab, rst at rs; every edge up to last is compared.
   task automatic run(input string nm, input int st2, input int ab, input int rs, input int last);
      int   k = 0;
      logic eb = 1'b0, ey = 1'b0, ed = 1'b0;
      do_reset(nm);
      for (int e = 0; e <= last; e++) begin
         start = (e == 0 || e == st2);
         abort = (e == ab);
         rst   = (e == rs);
         tick();
         if (k < tbl.size() && tbl[k].e == e) begin
            eb = tbl[k].b; ey = tbl[k].y; ed = tbl[k].d;
            k++;
         end
         chk($sformatf("%s btn@%0d", nm, e), {31'd0, btn_out}, {31'd0, eb});
         chk($sformatf("%s busy@%0d", nm, e), {31'd0, busy}, {31'd0, ey});
         chk($sformatf("%s done@%0d", nm, e), {31'd0, done}, {31'd0, ed});
      end
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      tbl.delete();
   endtask

   // Records the edges at which btn_r changes, starting with the start edge itself.
   task automatic rand_run(input string nm, output int chg[10], output int nchg);
      int   prev;
      bit   seen = 0;
      nchg = 0;
      for (int i = 0; i < 10; i++) chg[i] = -1;
      do_reset(nm);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, " start btn"}, {31'd0, btn_r}, 1);
      chg[0] = 0; nchg = 1; prev = 1;
      for (int e = 1; e <= 300 && !seen; e++) begin
         tick();
         if (int'(btn_r) != prev) begin
            if (nchg < 10) chg[nchg] = e;
            nchg++;
            prev = int'(btn_r);
         end
         if (done_r === 1'b1) begin
            seen = 1;
            chk({nm, " btn at done"}, {31'd0, btn_r}, 0);
            chk({nm, " busy at done"}, {31'd0, busy_r}, 0);
         end
      end
      chk({nm, " done seen"}, {31'd0, seen}, 1);
      chk({nm, " change count"}, nchg, 10);
      tick();
      chk({nm, " done cleared"}, {31'd0, done_r}, 0);
      chk({nm, " btn after done"}, {31'd0, btn_r}, 0);
   endtask

   initial begin : main
      int ca[10], cb[10];
      int na, nb;
      // Bounce intervals from SEED 16'hACE1 through the 16'hB400 Galois LFSR, low nibble + 3;
      // the fifth entry is the 10-cycle hold.
      int exp_ivl[9] = '{4, 3, 11, 15, 10, 17, 10, 6, 12};

      fill_normal(0, 999);
      run("normal", -1, -1, -1, 40);

      fill_normal(0, 999);
      run("start_busy", 10, -1, -1, 40);

      fill_normal(0, 14);
      add(15, 0, 0, 0);
      fill_normal(20, 999);
      run("abort_hold", 20, 15, -1, 60);

      fill_normal(0, 26);
      add(27, 0, 0, 0);
      run("rst_rbounce", -1, 30, 27, 40);

      fill_normal(0, 34);
      add(35, 1, 1, 0);
      add(38, 0, 1, 0);
      run("start_on_done", 35, -1, -1, 40);

      rand_run("rand1", ca, na);
      rand_run("rand2", cb, nb);
      for (int i = 0; i < 9; i++) begin
         int d;
         d = ca[i + 1] - ca[i];
         chk($sformatf("rand1 ivl%0d", i), d, exp_ivl[i]);
         if (i != 4) begin
            n_cmp++;
            if (d < 3 || d > 18) begin
               n_bad++;
               $display("FAIL rand1 range%0d: got %0d expected 3..18", i, d);
            end
         end
      end
      for (int i = 0; i < 10; i++)
         chk($sformatf("repeat chg%0d", i), cb[i], ca[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/btn_bounce_gen.md
BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter BOUNCE_N, default 6: number of bounce toggle pairs per edge burst; 0 = clean edges.
REQ-003 Parameter BOUNCE_MIN, default 100: minimum interval, in clk cycles, between bounce toggles; legal range 1..65535.
REQ-004 Parameter BOUNCE_MASK, default 16'h03FF: AND-mask applied to the LFSR to form the random interval extension.
REQ-005 Parameter HOLD_CYC, default 200000: number of cycles of stable pressed level; legal range 1..2^24-1.
REQ-006 Parameter SEED, default 16'hACE1: nonzero LFSR reset value.
REQ-007 Port clk, input, 1 bit: system clock; all logic is clocked on the rising edge.
REQ-008 Port rst, input, 1 bit: synchronous active-high reset.
REQ-009 Port start, input, 1 bit: request one press/release sequence; sampled only in IDLE.
REQ-010 Port abort, input, 1 bit: terminates any sequence in progress.
REQ-011 Port btn_out, output, 1 bit: emulated mechanical contact, active high, registered.
REQ-012 Port busy, output, 1 bit: high while a sequence is in progress, registered.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a sequence completes normally, registered.

Function
REQ-014 The FSM SHALL have four states: IDLE, P_BOUNCE, HOLD, R_BOUNCE.
REQ-015 The 16-bit Galois LFSR (mask 16'hB400) SHALL advance exactly once per interval load, so the sequence is deterministic from reset.
REQ-016 Interval L SHALL be BOUNCE_MIN + (lfsr & BOUNCE_MASK), computed 17 bits wide with no overflow.
REQ-017 IDLE with start=1 at edge T: btn_out<=1, busy<=1, state<=P_BOUNCE, interval counter loaded with L.
REQ-018 In P_BOUNCE, btn_out SHALL toggle exactly L cycles after the previous toggle, reloading a new L at each toggle.
REQ-019 P_BOUNCE SHALL end at the 2*BOUNCE_N-th toggle, with btn_out=1; the same edge enters HOLD with the hold counter loaded with HOLD_CYC.
REQ-020 HOLD SHALL keep btn_out=1; exactly HOLD_CYC cycles after entry: btn_out<=0, state<=R_BOUNCE, interval counter loaded.
REQ-021 R_BOUNCE SHALL toggle as in REQ-018 and end at the 2*BOUNCE_N-th toggle, with btn_out=0.
REQ-022 At the edge ending R_BOUNCE: state<=IDLE, busy<=0, done<=1; done clears on the next edge.
REQ-023 BOUNCE_N=0: P_BOUNCE and R_BOUNCE SHALL be bypassed.
  - start edge sets btn_out=1 and enters HOLD directly.
  - HOLD expiry sets btn_out=0, done=1 and returns to IDLE.
REQ-024 start while busy SHALL be ignored and not queued.
REQ-025 start in the cycle done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-026 abort=1 in any non-IDLE state at an edge SHALL force btn_out<=0, busy<=0, state<=IDLE, with no done pulse.
REQ-027 abort SHALL take priority over start and over a coincident toggle or timer expiry.
REQ-028 abort in IDLE SHALL be a no-op; the LFSR state is retained across abort.
REQ-029 btn_out SHALL change only at timer expiry, start acceptance, abort or reset.
  - btn_out SHALL be glitch-free (direct flop output).

Reset
REQ-030 rst=1 at an edge SHALL set the following, overriding abort/start and any operation in progress:
  - state=IDLE, btn_out=0, busy=0, done=0;
  - lfsr=SEED, all counters=0.
REQ-031 After rst deasserts, the first start SHALL be accepted on the first edge with rst=0.

Verification
Bench parameters for all scenarios: BOUNCE_N=2, BOUNCE_MIN=3, BOUNCE_MASK=0, HOLD_CYC=10; start pulsed one cycle at edge 0.
REQ-032 Normal sequence -> btn_out checked at each edge:
  - edge 0 -> btn_out=1;
  - edges 3/6/9/12 -> 0/1/0/1;
  - edge 22 -> 0;
  - edges 25/28/31/34 -> 1/0/1/0;
  - edge 34 -> busy=0, done=1 for exactly one cycle; busy=1 from edge 0 to 33.
REQ-033 Second start at edge 10 (busy) -> ignored; waveform identical to REQ-032, exactly one done pulse.
REQ-034 abort at edge 15 (HOLD) -> btn_out=0 and busy=0 after edge 15, no done pulse; a new start at edge 20 restarts the REQ-032 timing offset by 20.
REQ-035 rst at edge 27 (R_BOUNCE) -> btn_out=0, busy=0, done=0 from edge 27; no further toggles.
REQ-036 Random intervals:
  - Stimulus: BOUNCE_MASK=16'h000F, two sequences, each run immediately after a reset.
  - Required: identical toggle timestamps across both runs.
  - Required: every interval in 3..18.
  - Required: btn_out=0 after done each time.
